// File: rtl/zbuffer_write_stage.sv
// zbuffer_write_stage
//   Depth-tested fragment writer in front of port A of the framebuffer RAM
//   (2-cycle read latency). Each RAM word is {color, depth}. For every
//   fragment it reads the stored depth and writes the fragment back only if
//   the fragment is strictly nearer (smaller depth). It also sweeps the whole
//   buffer to {CLEAR_COLOR, all-ones depth} on request.
//
// Ports
//   clka, rstb                  clock, synchronous active-high reset
//   clear_req / clear_busy / clear_done   clear handshake
//   frag_valid / frag_ready, frag_x, frag_y, frag_z, frag_color
//                               fragment input (accepted on valid & ready)
//   ram_addr, ram_din, ram_en, ram_we, ram_regce, ram_rst, ram_dout
//                               RAM port A
//   written_count, rejected_count   wrapping depth-test statistics
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting; read address driven combinationally on accept
// S_RD1   | second cycle of the RAM read, address held
// S_CMP   | ram_dout valid; conditional write-back
// S_CLEAR | one clear write per cycle across the whole buffer
module zbuffer_write_stage #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 180,
  parameter int COLOR_W = 16,
  parameter int DEPTH_W = 16,
  parameter int ADDR_W  = 16,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                       clka,
  input  logic                       rstb,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done,
  input  logic                       frag_valid,
  output logic                       frag_ready,
  input  logic [15:0]                frag_x,
  input  logic [15:0]                frag_y,
  input  logic [DEPTH_W-1:0]         frag_z,
  input  logic [COLOR_W-1:0]         frag_color,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [COLOR_W+DEPTH_W-1:0] ram_din,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic                       ram_regce,
  output logic                       ram_rst,
  input  logic [COLOR_W+DEPTH_W-1:0] ram_dout,
  output logic [15:0]                written_count,
  output logic [15:0]                rejected_count
);

  localparam int WORD_W = COLOR_W + DEPTH_W;
  localparam int N_PIX  = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD1   = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]         state;
  logic               clear_pending;
  logic               clear_done_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  clr_addr;
  logic [DEPTH_W-1:0] z_q;
  logic [COLOR_W-1:0] color_q;

  logic               accept;
  logic               in_range;
  logic               depth_pass;
  logic [32:0]        pix_addr_full;
  logic [ADDR_W-1:0]  addr_in;

  logic               en_c;
  logic               we_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [WORD_W-1:0]  din_c;

  logic               unused_bits;

  assign frag_ready = (state == S_IDLE) && !clear_req && !clear_pending && !rstb;
  assign accept     = frag_valid && frag_ready;
  assign in_range   = (32'(frag_x) < H_RES) && (32'(frag_y) < V_RES);

  // Full-width address, truncated afterwards; out-of-range fragments never
  // reach the RAM, so truncation only matters for undersized ADDR_W.
  assign pix_addr_full = 33'(frag_y) * 33'(H_RES) + 33'(frag_x);
  assign addr_in       = pix_addr_full[ADDR_W-1:0];

  // Strictly nearer wins; equal depth keeps the stored pixel.
  assign depth_pass = z_q < ram_dout[DEPTH_W-1:0];

  assign unused_bits = ^{ram_dout[WORD_W-1:DEPTH_W], pix_addr_full};

  always_comb begin
    en_c   = 1'b0;
    we_c   = 1'b0;
    addr_c = '0;
    din_c  = '0;
    case (state)
      S_IDLE: begin
        if (accept && in_range) begin
          en_c   = 1'b1;
          addr_c = addr_in;
        end
      end
      S_RD1: begin
        en_c   = 1'b1;
        addr_c = addr_q;
      end
      S_CMP: begin
        addr_c = addr_q;
        if (depth_pass) begin
          en_c  = 1'b1;
          we_c  = 1'b1;
          din_c = {color_q, z_q};
        end
      end
      default: begin
        en_c   = 1'b1;
        we_c   = 1'b1;
        addr_c = clr_addr;
        din_c  = {CLEAR_COLOR, {DEPTH_W{1'b1}}};
      end
    endcase
  end

  // Gating with rstb guarantees no RAM write in the cycle reset is applied,
  // even though the state register only clears at the next edge.
  assign ram_en     = en_c && !rstb;
  assign ram_we     = we_c && !rstb;
  assign ram_addr   = rstb ? '0 : addr_c;
  assign ram_din    = rstb ? '0 : din_c;
  assign ram_regce  = 1'b1;
  assign ram_rst    = rstb;
  assign clear_busy = (state == S_CLEAR) && !rstb;
  assign clear_done = clear_done_q && !rstb;

  always_ff @(posedge clka) begin
    if (rstb) begin
      state          <= S_IDLE;
      clear_pending  <= 1'b0;
      clear_done_q   <= 1'b0;
      addr_q         <= '0;
      clr_addr       <= '0;
      z_q            <= '0;
      color_q        <= '0;
      written_count  <= '0;
      rejected_count <= '0;
    end else begin
      clear_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state          <= S_CLEAR;
            clr_addr       <= '0;
            written_count  <= '0;
            rejected_count <= '0;
          end else if (accept) begin
            if (in_range) begin
              addr_q  <= addr_in;
              z_q     <= frag_z;
              color_q <= frag_color;
              state   <= S_RD1;
            end else begin
              rejected_count <= rejected_count + 16'd1;
            end
          end
        end
        S_RD1: begin
          if (clear_req) clear_pending <= 1'b1;
          state <= S_CMP;
        end
        S_CMP: begin
          if (depth_pass) written_count  <= written_count + 16'd1;
          else            rejected_count <= rejected_count + 16'd1;
          if (clear_pending || clear_req) begin
            // Entering the sweep zeroes the statistics, overriding this
            // fragment's increment.
            state          <= S_CLEAR;
            clear_pending  <= 1'b0;
            clr_addr       <= '0;
            written_count  <= '0;
            rejected_count <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (clr_addr == LAST_ADDR) begin
            clear_done_q <= 1'b1;
            state        <= S_IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/zbuffer_write_stage.md
# zbuffer_write_stage

Depth-tested fragment writer that sits directly upstream of port A of the framebuffer dual-port RAM (HIGH_PERFORMANCE, 2-cycle read latency). Each word stores `{color, depth}`. For every incoming fragment, the block reads the stored depth, compares it with the fragment depth and writes the new word back only when the fragment is nearer. It also runs a full-buffer clear sequence. Port B of the same RAM is owned by the display scan-out.

## Interface

Parameters:
- `H_RES`, 320, framebuffer width in pixels
- `V_RES`, 180, framebuffer height in pixels
- `COLOR_W`, 16, color field width
- `DEPTH_W`, 16, depth field width; smaller value is nearer
- `ADDR_W`, 16, RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- `CLEAR_COLOR`, 0, color written during clear

Ports:
- `clka`  in  1  clock (shared with RAM port A)
- `rstb`  in  1  reset, synchronous, active-high
- `clear_req`  in  1  single-cycle request to clear the whole buffer
- `clear_busy`  out  1  high while the clear sweep is running
- `clear_done`  out  1  single-cycle pulse after the last clear write
- `frag_valid`  in  1  fragment valid
- `frag_ready`  out  1  fragment accepted when `frag_valid && frag_ready`
- `frag_x`  in  16  pixel x
- `frag_y`  in  16  pixel y
- `frag_z`  in  DEPTH_W  fragment depth
- `frag_color`  in  COLOR_W  fragment color
- `ram_addr`  out  ADDR_W  port A address
- `ram_din`  out  COLOR_W+DEPTH_W  port A write data, `{color, depth}`
- `ram_en`  out  1  port A enable
- `ram_we`  out  1  port A write enable
- `ram_regce`  out  1  port A output register enable; tied to 1
- `ram_rst`  out  1  port A output reset; equals `rstb`
- `ram_dout`  in  COLOR_W+DEPTH_W  port A read data (2-cycle latency)
- `written_count`  out  16  fragments that passed the depth test; wraps
- `rejected_count`  out  16  fragments that failed the depth test or were out of range; wraps

## Operation

- FSM states: IDLE, RD1, CMP, CLEAR.
- `frag_ready = (state==IDLE) && !clear_req && !clear_pending`. This is combinational, and is 0 during reset.
- IDLE, when a fragment is accepted in range:
  - Register `frag_z`, `frag_color` and `addr = frag_y*H_RES + frag_x`. Address arithmetic is full width, then truncated to ADDR_W.
  - Drive `ram_en=1`, `ram_we=0`, `ram_addr=addr` in the same cycle (combinational from the inputs).
  - Next state is RD1.
- IDLE, when an accepted fragment has `frag_x>=H_RES` or `frag_y>=V_RES`:
  - No RAM access.
  - `rejected_count++`.
  - Stay in IDLE; ready again next cycle.
- RD1: `ram_en=1`, `ram_addr` held. Next state is CMP.
- CMP: `ram_dout` is valid this cycle.
  - If `frag_z < ram_dout[DEPTH_W-1:0]`: drive `ram_en=1`, `ram_we=1`, `ram_din={color,z}`, and `written_count++`.
  - Otherwise: no write, and `rejected_count++`.
  - Equal depth is rejected.
  - Next state is IDLE, or CLEAR if `clear_pending`.
- Clear request handling:
  - `clear_req` in IDLE enters CLEAR next cycle and takes priority over a simultaneous `frag_valid`; the fragment is not accepted.
  - `clear_req` in RD1 or CMP sets `clear_pending`; CLEAR starts after CMP.
  - `clear_req` during CLEAR is ignored.
- CLEAR:
  - Writes `{CLEAR_COLOR, {DEPTH_W{1'b1}}}` to addresses 0..H_RES*V_RES-1, one per cycle, with `ram_en=ram_we=1`.
  - `clear_busy=1`.
  - On entry, both counters reset to 0.
  - After the last address: one-cycle `clear_done`, then IDLE.
- Reset values: state IDLE, `clear_busy=0`, `clear_done=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_din=0`, counters 0, `clear_pending=0`.
- Reset mid-operation: an in-flight fragment or clear sweep is abandoned with no further RAM writes. RAM contents are not restored.

## Timing

- Accepted fragment at cycle t:
  - read address presented in cycle t;
  - `ram_dout` sampled in cycle t+2;
  - conditional write committed at the clock edge ending cycle t+2;
  - `frag_ready` high again in cycle t+3.
- Throughput: 1 fragment per 3 cycles. Back-to-back fragments to the same pixel are safe, because a write commits before the next read is issued.
- Out-of-range fragment: 1 cycle, with counter update visible in cycle t+1.
- Clear: `clear_busy` high from cycle c+1 for H_RES*V_RES cycles; `clear_done` pulses in the cycle after the last write.
- Port B may read concurrently. Same-address port A write / port B read returns the old data on port B; this is accepted.

## Test plan

- Reset, then `clear_req`:
  - 57600 writes of `{0, 0xFFFF}` at addresses 0..57599;
  - `clear_done` pulse exactly 57601 cycles after the request;
  - counters 0.
- After clear, fragment (10, 2, z=0x1000, color=0xABCD):
  - read at addr 650;
  - write `0xABCD1000` in cycle t+2;
  - `written_count=1`.
- Same pixel again:
  - with z=0x2000: no write, `rejected_count=1`;
  - with z=0x1000: no write (equal depth rejected);
  - with z=0x0800: write `0x????0800` with the new color.
- Fragment x=320, y=0: no `ram_en`, `rejected_count++`, `frag_ready` high the next cycle.
- `clear_req` asserted in the RD1 cycle of a fragment: that fragment's CMP completes, then CLEAR starts the following cycle; `frag_ready` stays low throughout.
- `rstb` asserted mid-clear at address 100: no writes after reset; state IDLE; `clear_busy=0`; `frag_ready` high the cycle after `rstb` deasserts.
